sdram_port_arbiter: RTL and testbench

Shares the single SDRAM controller port between the instruction-cache line-refill requester and the data load/store requester.
- Icache refill: fixed-length burst of BURST_LEN words, line-aligned.
- Data requester: single-word read or byte-masked write.
- Sits between the instruction cache, the data memory unit and the SDRAM controller, all on cpu_clk.
- Fixed data priority, with an anti-starvation limit for instruction fetch.

---
 rtl/sdram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller port between icache refills and data accesses.
// Optional: define SDRAM_ARB_TIMEOUT_EN for a mem_ack watchdog with NOP fill and err_timeout.
module sdram_port_arbiter #(
   parameter int unsigned ADDR_W       = 21,
   parameter int unsigned BURST_LEN    = 16,
   parameter int unsigned MAX_D_CONSEC = 4,
   parameter int unsigned TIMEOUT      = 1023
) (
   input  logic                         cpu_clk,
   input  logic                         reset_n,
   input  logic                         ic_req,
   input  logic [ADDR_W-1:0]            ic_addr,
   output logic                         ic_ack,
   output logic [31:0]                  ic_rdata,
   output logic [$clog2(BURST_LEN)-1:0] ic_ptr,
   input  logic                         d_req,
   input  logic                         d_we,
   input  logic [ADDR_W-1:0]            d_addr,
   input  logic [31:0]                  d_wdata,
   input  logic [3:0]                   d_be,
   output logic                         d_ack,
   output logic [31:0]                  d_rdata,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic [3:0]                   mem_be,
   input  logic [31:0]                  mem_rdata,
   input  logic                         mem_ack,
   output logic                         busy
`ifdef SDRAM_ARB_TIMEOUT_EN
   ,output logic                        err_timeout
`endif
);

   localparam int unsigned PW = $clog2(BURST_LEN);
   localparam int unsigned SW = $clog2(MAX_D_CONSEC + 1);
   localparam logic [PW-1:0] LAST = PW'(BURST_LEN - 1);
   localparam logic [SW-1:0] SMAX = SW'(MAX_D_CONSEC);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_IC_BURST,
      S_D_ACCESS,
      S_RELEASE
   } state_t;

   state_t        state_q;
   logic [PW-1:0] idx_q;
   logic [SW-1:0] starve_q;
   logic          tmo_hit;
   logic          fill_on;
   logic          unused_ok;

   // Line-offset bits of the refill address are dropped by design.
   assign unused_ok = ^{ic_addr[PW-1:0], TIMEOUT[0]};

   assign busy = (state_q != S_IDLE);

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmo_q;
   logic          fill_q;
   logic          err_q;

   assign tmo_hit     = mem_req && !mem_ack && (tmo_q == TW'(TIMEOUT - 1));
   assign fill_on     = fill_q;
   assign err_timeout = err_q;

   // Watchdog on the outstanding word; after an abort the rest of the line is NOP-filled.
   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q  <= '0;
         fill_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (mem_req && !mem_ack && !tmo_hit) tmo_q <= tmo_q + TW'(1);
         else                                 tmo_q <= '0;
         if (tmo_hit) err_q <= 1'b1;
         if (tmo_hit && state_q == S_IC_BURST && idx_q != LAST) fill_q <= 1'b1;
         else if (fill_q && idx_q == LAST)                      fill_q <= 1'b0;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign fill_on = 1'b0;
`endif

   // Arbitration FSM; every port-side output is registered here.
   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         starve_q  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         ic_ack    <= 1'b0;
         ic_rdata  <= '0;
         ic_ptr    <= '0;
         d_ack     <= 1'b0;
         d_rdata   <= '0;
      end else begin
         ic_ack <= 1'b0;
         d_ack  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (!ic_req) starve_q <= '0;
               if (ic_req && (!d_req || starve_q == SMAX)) begin
                  state_q   <= S_IC_BURST;
                  starve_q  <= '0;
                  idx_q     <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= {ic_addr[ADDR_W-1:PW], {PW{1'b0}}};
                  mem_wdata <= '0;
                  mem_be    <= 4'hF;
               end else if (d_req) begin
                  state_q   <= S_D_ACCESS;
                  if (ic_req) starve_q <= starve_q + SW'(1);
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_be    <= d_we ? d_be : 4'hF;
               end
            end
            S_D_ACCESS: begin
               if (mem_ack || tmo_hit) begin
                  state_q   <= S_RELEASE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  mem_be    <= '0;
                  d_ack     <= 1'b1;
                  d_rdata   <= mem_ack ? mem_rdata : NOP;
               end
            end
            S_IC_BURST: begin
               if (mem_ack || tmo_hit || fill_on) begin
                  ic_ack   <= 1'b1;
                  ic_rdata <= (mem_req && mem_ack) ? mem_rdata : NOP;
                  ic_ptr   <= idx_q;
                  idx_q    <= idx_q + PW'(1);
                  if (idx_q == LAST) begin
                     state_q  <= S_RELEASE;
                     mem_req  <= 1'b0;
                     mem_addr <= '0;
                     mem_be   <= '0;
                  end else if (tmo_hit) begin
                     mem_req  <= 1'b0;
                     mem_addr <= '0;
                     mem_be   <= '0;
                  end else if (!fill_on) begin
                     mem_addr <= mem_addr + ADDR_W'(1);
                  end
               end
            end
            S_RELEASE: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed, burst, starvation,
// wait, reset and timeout sequences.
module tb_sdram_port_arbiter;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 1023;
`endif

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ic_req, ic_ack;
  logic [20:0] ic_addr;
  logic [31:0] ic_rdata;
  logic [3:0]  ic_ptr;
  logic        d_req, d_we, d_ack;
  logic [20:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ack;
  logic [20:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy;
`ifdef SDRAM_ARB_TIMEOUT_EN
  logic        err_timeout;
`endif

  sdram_port_arbiter #(.TIMEOUT(TMO)) dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .ic_ptr(ic_ptr),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_ack(d_ack),
    .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
`ifdef SDRAM_ARB_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h",
                  nm, act, exp);
  endtask

  logic ctrl_en = 1'b1;
  int   ack_lat = 3;
  int   wcnt    = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge cpu_clk);
      #1;
      if (ctrl_en && mem_req && !mem_ack) begin
        wcnt++;
        if (wcnt >= ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hA000_0000 | 32'(mem_addr);
          wcnt      = 0;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  exp_be;
    logic [31:0] exp_rd;
    logic        chk_rd;
  } dvec_t;

  dvec_t vec[5];

  function automatic logic outs_nonzero();
    return |{mem_req, mem_we, mem_addr, mem_wdata,
             mem_be, ic_ack, ic_rdata, ic_ptr,
             d_ack, d_rdata, busy};
  endfunction

  task automatic run_data(input dvec_t v);
    logic got, icseen;
    d_we = v.we; d_addr = v.addr;
    d_wdata = v.wdata; d_be = v.be; d_req = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge cpu_clk);
      got = mem_req;
    end
    chk("d_grant", 32'(got), 1);
    chk("d_mem_we", 32'(mem_we), 32'(v.we));
    chk("d_mem_addr", 32'(mem_addr), 32'(v.addr));
    chk("d_mem_be", 32'(mem_be), 32'(v.exp_be));
    chk("d_busy", 32'(busy), 1);
    if (v.we) chk("d_mem_wdata", mem_wdata, v.wdata);
    d_addr = ~v.addr;
    d_wdata = ~v.wdata;
    @(negedge cpu_clk);
    chk("d_hold_addr", 32'(mem_addr), 32'(v.addr));
    got = 1'b0;
    icseen = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge cpu_clk);
      got = d_ack;
      icseen |= ic_ack;
    end
    chk("d_ack", 32'(got), 1);
    chk("d_ic_quiet", 32'(icseen), 0);
    if (v.chk_rd) chk("d_rdata", d_rdata, v.exp_rd);
    @(posedge cpu_clk);
    #1 d_req = 1'b0;
    @(negedge cpu_clk);
    chk("d_ack_single", 32'(d_ack), 0);
    chk("d_idle", 32'(busy), 0);
  endtask

  initial begin
    int          ptr, perr, derr, aerr, werr, icn;
    int          cyc, fin, wecyc, early;
    logic        prev, drop, done, raise;
    logic        fin_seen, dack, got;
    logic [20:0] gq[$];
    logic [20:0] gexp[6];

    vec[0] = '{1'b1, 21'h01000, 32'hDEADBEEF,
               4'b0011, 4'b0011, 32'h0, 1'b0};
    vec[1] = '{1'b0, 21'h0ABCD, 32'h0,
               4'b0000, 4'hF, 32'hA000ABCD, 1'b1};
    vec[2] = '{1'b1, 21'h1FFFFF, 32'h12345678,
               4'b1100, 4'b1100, 32'h0, 1'b0};
    vec[3] = '{1'b0, 21'h00000, 32'h0,
               4'b0101, 4'hF, 32'hA0000000, 1'b1};
    vec[4] = '{1'b0, 21'h1F000, 32'hFFFFFFFF,
               4'b1000, 4'hF, 32'hA001F000, 1'b1};
    gexp = '{21'h05000, 21'h05000, 21'h05000,
             21'h05000, 21'h00200, 21'h05000};

    ic_req = 0; ic_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (3) @(negedge cpu_clk);
    chk("rst_outputs", 32'(outs_nonzero()), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    @(negedge cpu_clk);

    ack_lat = 3;
    for (int i = 0; i < 5; i++) run_data(vec[i]);

    ic_addr = 21'h00123; ic_req = 1'b1;
    ptr = 0; perr = 0; derr = 0; aerr = 0; werr = 0;
    for (int t = 0; t < 300 && ptr < 16; t++) begin
      @(negedge cpu_clk);
      if (ic_ack) begin
        if (ic_ptr !== 4'(ptr)) perr++;
        if (ic_rdata !== (32'hA000_0120 + 32'(ptr)))
          derr++;
        ptr++;
      end
      if (mem_req &&
          mem_addr !== 21'(32'h120 + 32'(ptr)))
        aerr++;
      if (mem_req && mem_we) werr++;
    end
    chk("burst_words", 32'(ptr), 16);
    chk("burst_ptr_errs", 32'(perr), 0);
    chk("burst_data_errs", 32'(derr), 0);
    chk("burst_addr_errs", 32'(aerr), 0);
    chk("burst_we_errs", 32'(werr), 0);
    chk("burst_release", {30'b0, busy, mem_req},
        32'b10);
    @(posedge cpu_clk);
    #1 ic_req = 1'b0;
    @(negedge cpu_clk);
    chk("burst_idle", {30'b0, busy, ic_ack}, 0);

    ack_lat = 1;
    @(negedge cpu_clk);
    ic_addr = 21'h00200; ic_req = 1'b1;
    d_addr = 21'h05000; d_we = 1'b0;
    d_be = 4'hF; d_req = 1'b1;
    prev = 0; icn = 0; done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge cpu_clk);
      if (mem_req && !prev) gq.push_back(mem_addr);
      prev = mem_req;
      if (ic_ack) icn++;
      drop = ic_ack && ic_ptr == 4'hF;
      done = d_ack && gq.size() == 6;
      @(posedge cpu_clk);
      #1;
      if (drop) ic_req = 1'b0;
      if (done) d_req = 1'b0;
    end
    chk("starve_done", 32'(done), 1);
    chk("starve_grants", 32'(gq.size()), 6);
    if (gq.size() == 6)
      for (int i = 0; i < 6; i++)
        chk($sformatf("starve_grant%0d", i),
            32'(gq[i]), 32'(gexp[i]));
    chk("starve_ic_words", 32'(icn), 16);
    @(negedge cpu_clk);
    @(negedge cpu_clk);

    ack_lat = 3;
    ic_addr = 21'h00300; ic_req = 1'b1;
    d_we = 1'b1; d_addr = 21'h07777;
    d_wdata = 32'h55AA55AA; d_be = 4'hF; d_req = 1'b0;
    cyc = 0; fin = 0; wecyc = 0; early = 0;
    fin_seen = 0; dack = 0; done = 0; raise = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge cpu_clk);
      cyc++;
      if (mem_we && !fin_seen) early++;
      raise = ic_ack && ic_ptr == 4'd4;
      drop = ic_ack && ic_ptr == 4'hF;
      if (drop) begin
        fin = cyc;
        fin_seen = 1'b1;
      end
      if (fin_seen && mem_we && wecyc == 0)
        wecyc = cyc;
      if (d_ack) begin
        dack = 1'b1;
        done = 1'b1;
      end
      @(posedge cpu_clk);
      #1;
      if (raise) d_req = 1'b1;
      if (drop) ic_req = 1'b0;
      if (done) d_req = 1'b0;
    end
    chk("wait_no_early_we", 32'(early), 0);
    chk("wait_burst_done", 32'(fin_seen), 1);
    chk("wait_grant_delay", 32'(wecyc - fin), 2);
    chk("wait_d_ack", 32'(dack), 1);
    @(negedge cpu_clk);
    @(negedge cpu_clk);

    ic_addr = 21'h00400; ic_req = 1'b1;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge cpu_clk);
      got = ic_ack && ic_ptr == 4'd6;
    end
    chk("rst_burst_reached", 32'(got), 1);
    @(posedge cpu_clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'(outs_nonzero()), 0);
    ic_req = 1'b0;
    repeat (2) @(negedge cpu_clk);
    reset_n = 1'b1;
    @(negedge cpu_clk);
    ic_addr = 21'h00405; ic_req = 1'b1;
    got = 0;
    prev = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge cpu_clk);
      if (mem_req && !prev)
        chk("rst_restart_addr", 32'(mem_addr),
            32'h400);
      prev = mem_req;
      got = ic_ack;
    end
    chk("rst_restart_ack", 32'(got), 1);
    chk("rst_restart_ptr", 32'(ic_ptr), 0);
    chk("rst_restart_data", ic_rdata, 32'hA0000400);
    @(posedge cpu_clk);
    #3 reset_n = 1'b0;
    ic_req = 1'b0;
    repeat (2) @(negedge cpu_clk);
    reset_n = 1'b1;
    @(negedge cpu_clk);

`ifdef SDRAM_ARB_TIMEOUT_EN
    ctrl_en = 1'b0;
    d_we = 1'b0; d_addr = 21'h00010; d_req = 1'b1;
    cyc = 0; got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge cpu_clk);
      if (mem_req || cyc > 0) cyc++;
      got = d_ack;
    end
    chk("tmo_ack_cycle", 32'(cyc), 9);
    chk("tmo_rdata", d_rdata, 32'h00000013);
    chk("tmo_err", 32'(err_timeout), 1);
    @(posedge cpu_clk);
    #1 d_req = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
